pixel_assembler: RTL and testbench

PIXEL_ASSEMBLER -- requirements
Module: pixel_assembler

---
 rtl/camara_pkg.sv | 17 +
 rtl/pixel_counter.sv | 65 ++++++
 rtl/pixel_assembler.sv | 100 ++++++++++
 tb/tb_pixel_assembler.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/camara_pkg.sv
// Shared camera-pipeline constants: frame geometry defaults, coordinate widths
// and the pixel assembler state encoding.
package camara_pkg;

  localparam int unsigned H_ACTIVE_DEF = 160;
  localparam int unsigned V_ACTIVE_DEF = 120;
  localparam int unsigned X_W          = 9;
  localparam int unsigned Y_W          = 8;
  localparam int unsigned ST_W         = 3;

  localparam logic [ST_W-1:0] REQ_HI  = 3'd0;
  localparam logic [ST_W-1:0] WAIT_HI = 3'd1;
  localparam logic [ST_W-1:0] REQ_LO  = 3'd2;
  localparam logic [ST_W-1:0] WAIT_LO = 3'd3;
  localparam logic [ST_W-1:0] OUT     = 3'd4;

endpackage

// File: rtl/pixel_counter.sv
// Raster position counter: advances on each accepted pixel, wraps at line and
// frame boundaries, and pulses frame_done after the last pixel of a frame.
module pixel_counter
  import camara_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clear,
  input  logic           advance,
  output logic [X_W-1:0] pix_x,
  output logic [Y_W-1:0] pix_y,
  output logic           frame_done
);

  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic           frame_done_q, frame_done_d;
  logic           last_x, last_y;

  assign last_x = (x_q == X_W'(H_ACTIVE - 1));
  assign last_y = (y_q == Y_W'(V_ACTIVE - 1));

  // clear outranks advance so a restart never produces a coordinate step or pulse
  always_comb begin
    x_d          = x_q;
    y_d          = y_q;
    frame_done_d = 1'b0;
    if (clear) begin
      x_d = '0;
      y_d = '0;
    end else if (advance) begin
      if (last_x) begin
        x_d = '0;
        if (last_y) begin
          y_d          = '0;
          frame_done_d = 1'b1;
        end else begin
          y_d = y_q + Y_W'(1);
        end
      end else begin
        x_d = x_q + X_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q          <= '0;
      y_q          <= '0;
      frame_done_q <= 1'b0;
    end else begin
      x_q          <= x_d;
      y_q          <= y_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign pix_x      = x_q;
  assign pix_y      = y_q;
  assign frame_done = frame_done_q;

endmodule

// File: rtl/pixel_assembler.sv
// Pops big-endian RGB565 byte pairs from the camera FIFO and presents them as
// pixels with raster coordinates under a valid/ready handshake.
module pixel_assembler
  import camara_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sync_clear,
  input  logic        empty,
  input  logic [7:0]  dout,
  output logic        rd,
  output logic [15:0] pix_data,
  output logic [8:0]  pix_x,
  output logic [7:0]  pix_y,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        frame_done
);

  logic [ST_W-1:0] state_q, state_d;
  logic [15:0]     data_q, data_d;
  logic            valid_q, valid_d;
  logic            run_q;
  logic            handshake;

  assign handshake = valid_q & pix_ready;

  // rd is combinational so it can react to empty in the same cycle; run_q
  // holds it off until the first clock edge after reset is released
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    rd      = 1'b0;
    if (sync_clear) begin
      state_d = REQ_HI;
    end else begin
      case (state_q)
        REQ_HI: begin
          if (!empty && run_q) begin
            rd      = 1'b1;
            state_d = WAIT_HI;
          end
        end
        WAIT_HI: begin
          data_d[15:8] = dout;
          state_d      = REQ_LO;
        end
        REQ_LO: begin
          if (!empty && run_q) begin
            rd      = 1'b1;
            state_d = WAIT_LO;
          end
        end
        WAIT_LO: begin
          data_d[7:0] = dout;
          state_d     = OUT;
        end
        OUT: begin
          if (pix_ready) state_d = REQ_HI;
        end
        default: state_d = REQ_HI;
      endcase
    end
    valid_d = (state_d == OUT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= REQ_HI;
      data_q  <= '0;
      valid_q <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      run_q   <= 1'b1;
    end
  end

  pixel_counter #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE)
  ) u_counter (
    .clk        (clk),
    .reset      (reset),
    .clear      (sync_clear),
    .advance    (handshake),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .frame_done (frame_done)
  );

  assign pix_data  = data_q;
  assign pix_valid = valid_q;

endmodule

// File: tb/tb_pixel_assembler.sv
// Directed bench for pixel_assembler on a 4x3 frame with a behavioural camera FIFO.
module tb_pixel_assembler;

  localparam int unsigned HA = 4;
  localparam int unsigned VA = 3;

  logic        clk = 1'b0;
  logic        reset, sync_clear, empty, pix_ready;
  logic [7:0]  dout;
  logic        rd, pix_valid, frame_done;
  logic [15:0] pix_data;
  logic [8:0]  pix_x;
  logic [7:0]  pix_y;

  always #5 clk = ~clk;

  pixel_assembler #(.H_ACTIVE(HA), .V_ACTIVE(VA)) dut (
    .clk        (clk),
    .reset      (reset),
    .sync_clear (sync_clear),
    .empty      (empty),
    .dout       (dout),
    .rd         (rd),
    .pix_data   (pix_data),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .frame_done (frame_done)
  );

  typedef struct packed {
    logic [7:0]  hi;
    logic [7:0]  lo;
    logic [15:0] d;
    logic [8:0]  x;
    logic [7:0]  y;
    logic        fd;
  } vec_t;

  typedef struct packed {
    logic [15:0] d;
    logic [8:0]  x;
    logic [7:0]  y;
  } hs_t;

  int          errors = 0;
  int          checks = 0;
  logic [7:0]  fq[$];
  hs_t         hsq[$];
  logic        rand_empty = 1'b0;
  logic        prev_rd = 1'b0;
  logic        pend = 1'b0;
  logic [7:0]  pend_byte = 8'h00;
  int          pops = 0;
  int          fd_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: FIFO pop and handshake monitor on the falling edge, byte return after the rising edge
  task automatic tick();
    @(negedge clk);
    if (rd) begin
      chk("rd_while_empty", 32'(empty), 32'(0));
      chk("rd_back_to_back", 32'(prev_rd), 32'(0));
      if (fq.size() > 0) pend_byte = fq.pop_front();
      else pend_byte = 8'h00;
      pend = 1'b1;
      pops++;
    end
    prev_rd = rd;
    if (pix_valid && pix_ready && !sync_clear && !reset)
      hsq.push_back(hs_t'({pix_data, pix_x, pix_y}));
    if (frame_done) fd_cnt++;
    @(posedge clk);
    #1;
    if (pend) begin
      dout = pend_byte;
      pend = 1'b0;
    end
    empty = (fq.size() == 0) || (rand_empty && ($urandom_range(0, 1) == 1));
  endtask

  task automatic push(input logic [7:0] b);
    fq.push_back(b);
    if (!rand_empty) empty = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!pix_valid && n < 40) begin
      tick();
      n++;
    end
    chk("valid_timeout", 32'(pix_valid), 32'(1));
  endtask

  task automatic send_pixel(input logic [7:0] hi, input logic [7:0] lo, input int ex, input int ey);
    int n;
    push(hi);
    push(lo);
    pix_ready = 1'b1;
    wait_valid(n);
    chk("send_data", 32'(pix_data), 32'({hi, lo}));
    chk("send_x", 32'(pix_x), 32'(ex));
    chk("send_y", 32'(pix_y), 32'(ey));
    tick();
  endtask

  vec_t vecs[12];

  initial begin
    int n;
    int p0;
    int fd0;
    logic [15:0] hold_d;

    vecs[0]  = '{8'hF8, 8'h00, 16'hF800, 9'd0, 8'd0, 1'b0};
    vecs[1]  = '{8'h07, 8'hE0, 16'h07E0, 9'd1, 8'd0, 1'b0};
    vecs[2]  = '{8'h00, 8'h1F, 16'h001F, 9'd2, 8'd0, 1'b0};
    vecs[3]  = '{8'hFF, 8'hFF, 16'hFFFF, 9'd3, 8'd0, 1'b0};
    vecs[4]  = '{8'h12, 8'h34, 16'h1234, 9'd0, 8'd1, 1'b0};
    vecs[5]  = '{8'hAB, 8'hCD, 16'hABCD, 9'd1, 8'd1, 1'b0};
    vecs[6]  = '{8'h80, 8'h01, 16'h8001, 9'd2, 8'd1, 1'b0};
    vecs[7]  = '{8'h00, 8'h00, 16'h0000, 9'd3, 8'd1, 1'b0};
    vecs[8]  = '{8'h5A, 8'hA5, 16'h5AA5, 9'd0, 8'd2, 1'b0};
    vecs[9]  = '{8'hC3, 8'h3C, 16'hC33C, 9'd1, 8'd2, 1'b0};
    vecs[10] = '{8'h01, 8'h80, 16'h0180, 9'd2, 8'd2, 1'b0};
    vecs[11] = '{8'h7E, 8'hE7, 16'h7EE7, 9'd3, 8'd2, 1'b1};

    reset = 1'b1; sync_clear = 1'b0; empty = 1'b1; pix_ready = 1'b0; dout = 8'h00;
    tick();
    tick();
    chk("rst_rd", 32'(rd), 32'(0));
    chk("rst_valid", 32'(pix_valid), 32'(0));
    chk("rst_data", 32'(pix_data), 32'(0));
    chk("rst_x", 32'(pix_x), 32'(0));
    chk("rst_y", 32'(pix_y), 32'(0));
    chk("rst_fd", 32'(frame_done), 32'(0));
    reset = 1'b0;

    // Full 4x3 frame at full rate
    pix_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      p0 = pops;
      push(vecs[i].hi);
      push(vecs[i].lo);
      wait_valid(n);
      if (i == 0) chk("rd_per_byte", 32'(pops - p0), 32'(2));
      else chk("pixel_period", 32'(n), 32'(4));
      chk("vec_data", 32'(pix_data), 32'(vecs[i].d));
      chk("vec_x", 32'(pix_x), 32'(vecs[i].x));
      chk("vec_y", 32'(pix_y), 32'(vecs[i].y));
      tick();
      chk("vec_valid_1cyc", 32'(pix_valid), 32'(0));
      chk("vec_frame_done", 32'(frame_done), 32'(vecs[i].fd));
    end
    tick();
    chk("fd_single", 32'(frame_done), 32'(0));
    chk("fd_count", 32'(fd_cnt), 32'(1));
    chk("wrap_x", 32'(pix_x), 32'(0));
    chk("wrap_y", 32'(pix_y), 32'(0));

    // Backpressure with a byte waiting in the FIFO
    pix_ready = 1'b0;
    push(8'hA5); push(8'h5A); push(8'h11);
    wait_valid(n);
    chk("bp_data", 32'(pix_data), 32'(16'hA55A));
    chk("bp_x", 32'(pix_x), 32'(0));
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_stable", 32'({pix_valid, pix_data, pix_x, pix_y}), 32'({1'b1, 16'hA55A, 9'd0, 8'd0}));
      chk("bp_rd", 32'(rd), 32'(0));
    end
    pix_ready = 1'b1;
    tick();
    chk("bp_accept_valid", 32'(pix_valid), 32'(0));
    chk("bp_accept_x", 32'(pix_x), 32'(1));
    push(8'h22);
    wait_valid(n);
    chk("bp_next_data", 32'(pix_data), 32'(16'h1122));
    tick();

    // Walk to (2,1), then restart while the low byte is being returned
    send_pixel(8'h01, 8'h02, 2, 0);
    send_pixel(8'h03, 8'h04, 3, 0);
    send_pixel(8'h05, 8'h06, 0, 1);
    send_pixel(8'h07, 8'h08, 1, 1);
    push(8'hAA); push(8'hBB);
    p0 = pops + 2;
    n = 0;
    while (pops < p0 && n < 40) begin
      tick();
      n++;
    end
    chk("sc_reach_pops", 32'(pops), 32'(p0));
    chk("sc_at_x", 32'(pix_x), 32'(2));
    chk("sc_at_y", 32'(pix_y), 32'(1));
    sync_clear = 1'b1;
    tick();
    sync_clear = 1'b0;
    chk("sc_valid", 32'(pix_valid), 32'(0));
    chk("sc_x", 32'(pix_x), 32'(0));
    chk("sc_y", 32'(pix_y), 32'(0));
    fd0 = fd_cnt;
    push(8'h12); push(8'h34);
    wait_valid(n);
    chk("sc_data", 32'(pix_data), 32'(16'h1234));
    chk("sc_data_x", 32'(pix_x), 32'(0));
    chk("sc_data_y", 32'(pix_y), 32'(0));
    tick();
    chk("sc_no_fd", 32'(fd_cnt), 32'(fd0));

    // Restart coinciding with a handshake
    pix_ready = 1'b0;
    push(8'h56); push(8'h78);
    wait_valid(n);
    chk("schs_pre_x", 32'(pix_x), 32'(1));
    sync_clear = 1'b1;
    pix_ready = 1'b1;
    tick();
    sync_clear = 1'b0;
    chk("schs_x", 32'(pix_x), 32'(0));
    chk("schs_valid", 32'(pix_valid), 32'(0));
    chk("schs_fd", 32'(frame_done), 32'(0));

    // Asynchronous reset while a pixel is held
    send_pixel(8'h9A, 8'hBC, 0, 0);
    pix_ready = 1'b0;
    push(8'h77); push(8'h88);
    wait_valid(n);
    hold_d = pix_data;
    chk("ar_pre_data", 32'(hold_d), 32'(16'h7788));
    chk("ar_pre_x", 32'(pix_x), 32'(1));
    #2 reset = 1'b1;
    #1;
    chk("ar_valid", 32'(pix_valid), 32'(0));
    chk("ar_data", 32'(pix_data), 32'(0));
    chk("ar_x", 32'(pix_x), 32'(0));
    chk("ar_rd", 32'(rd), 32'(0));
    fq.delete();
    pend = 1'b0;
    tick();
    push(8'hF0); push(8'h0F);
    tick();
    #2 reset = 1'b0;
    #1;
    chk("ar_rd_release", 32'(rd), 32'(0));
    pix_ready = 1'b1;
    wait_valid(n);
    chk("ar_resume_data", 32'(pix_data), 32'(16'hF00F));
    chk("ar_resume_x", 32'(pix_x), 32'(0));
    tick();

    // Restart with bytes waiting, then a full frame under random empty/ready
    for (int k = 0; k < 24; k++) push(8'(k));
    sync_clear = 1'b1;
    #1;
    chk("sc_rd_gated", 32'(rd), 32'(0));
    p0 = pops;
    hsq.delete();
    tick();
    sync_clear = 1'b0;
    chk("sc_no_pop", 32'(pops), 32'(p0));
    chk("sc2_x", 32'(pix_x), 32'(0));
    rand_empty = 1'b1;
    fd0 = fd_cnt;
    n = 0;
    while (hsq.size() < 12 && n < 3000) begin
      pix_ready = ($urandom_range(0, 1) == 1);
      tick();
      n++;
    end
    pix_ready = 1'b1;
    rand_empty = 1'b0;
    tick();
    tick();
    chk("rnd_count", 32'(hsq.size()), 32'(12));
    for (int k = 0; k < 12 && k < hsq.size(); k++) begin
      chk("rnd_data", 32'(hsq[k].d), 32'({8'(2 * k), 8'(2 * k + 1)}));
      chk("rnd_x", 32'(hsq[k].x), 32'(k % 4));
      chk("rnd_y", 32'(hsq[k].y), 32'(k / 4));
    end
    chk("rnd_fd", 32'(fd_cnt), 32'(fd0 + 1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
